serv_mem_seq: RTL and testbench
===============================

Name: serv_mem_seq

Overview:
Sequencer for the bit-serial data buffer used for loads, stores and shifts in the SERV core.
- On a request it runs the 32-cycle init phase, issues the data-bus cycle and generates the buffer load strobe.
- For loads it then runs a 32-cycle shift-out phase; for shifts it runs the buffer's down-counter until the buffer reports done.
- Sits between the decoder/state logic and the data buffer, and owns the data-bus handshake.

Parameters:
MISALIGN_TRAP, 1, 1: a misaligned access skips the bus and pulses o_misalign; 0: access issued with the computed sel.
BUS_TIMEOUT, 255, max wait cycles for i_dbus_ack before abort (0 = wait forever); counter width is clog2(BUS_TIMEOUT+1).

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  start operation; sampled only in IDLE
i_shift_op  in  1  operation is a shift (no bus access)
i_store  in  1  mem op is a store (else load); ignored when i_shift_op=1
i_size  in  2  0=byte, 1=half, 2/3=word
i_lsb  in  2  address bits [1:0]
i_sh_done  in  1  buffer shift-count-expired flag
i_dbus_ack  in  1  data bus acknowledge
o_init  out  1  init phase active
o_en  out  1  buffer shift enable
o_cnt  out  5  bit counter
o_cnt_done  out  1  o_cnt==31 while in INIT or RUN
o_byte_valid  out  1  current bit lies in a valid byte lane
o_load  out  1  buffer capture strobe
o_dbus_cyc  out  1  bus cycle request
o_dbus_we  out  1  bus write
o_dbus_sel  out  4  byte select
o_misalign  out  1  one-cycle misalignment pulse
o_timeout  out  1  one-cycle bus timeout pulse
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, timeout counter=0, every output 0. Asserting reset mid-operation aborts immediately, and o_dbus_cyc drops asynchronously.
- States: IDLE, INIT, BUS, RUN, DONE.
- Request capture: on i_req in IDLE, latch shift_op, store, size and lsb. Inputs are ignored while busy.

State transitions:
- IDLE -> INIT on i_req.
- INIT: o_init=1, o_en=1, cnt increments each cycle from 0.
  - On cnt==31: shift -> RUN; misaligned with MISALIGN_TRAP=1 -> DONE with o_misalign=1 during that DONE cycle; otherwise -> BUS. cnt wraps to 0.
- BUS: o_dbus_cyc=1 (registered, asserted the first BUS cycle); o_dbus_we=store.
  - o_load = (state==BUS) & i_dbus_ack & ~store, combinational in the ack cycle.
  - On ack: store -> DONE, load -> RUN; cyc deasserts the next cycle.
  - If wait count reaches BUS_TIMEOUT with no ack: -> DONE, o_timeout=1 in DONE, o_load never asserted.
  - An ack arriving in the same cycle the count expires wins over the timeout.
- RUN (load): o_en=1 for exactly 32 cycles, cnt 0..31, then -> DONE.
- RUN (shift): o_en=1 until i_sh_done=1, then -> DONE on that cycle. cnt is free-running and wraps at 31.
- DONE: o_done=1 for one cycle -> IDLE. A new i_req is accepted from the next IDLE cycle, so there is at least one idle cycle between operations.

Address decode:
- sel: byte = 4'b0001<<lsb; half = 4'b0011<<lsb (lsb[1] only); word = 4'b1111.
- Misaligned: half with lsb[0]=1, or word with lsb!=0.

o_byte_valid, with b = cnt[4:3]:
- In INIT for a store: 1 when b>=lsb.
- In RUN for a load: 1 when b==0, or b==1 and size!=byte, or size==word.
- Otherwise 0.

Test Plan:
- Store byte, lsb=2, ack after 3 wait cycles -> 32 INIT cycles with byte_valid high for cnt>=16; cyc=1, we=1, sel=4'b0100 for 4 cycles; o_load never; o_done exactly 1 cycle later; total 32+4+1 busy cycles.
- Load word, lsb=0, ack on first BUS cycle -> o_load=1 in the ack cycle only, sel=4'b1111; RUN 32 cycles with byte_valid=1 throughout; cnt_done at cnt=31; then o_done.
- Load half, lsb=1, MISALIGN_TRAP=1 -> o_dbus_cyc never asserted; o_misalign and o_done both pulse in the cycle after INIT ends. Repeat with MISALIGN_TRAP=0 -> cyc asserted with sel=4'b0110.
- Shift op, i_sh_done driven high 6 cycles into RUN -> o_en high for 6 RUN cycles, no bus activity, o_done next cycle; i_req pulses during the op are ignored.
- BUS_TIMEOUT=4, no ack -> cyc high for 4 cycles, o_timeout and o_done pulse together, o_load=0. Separately, ack coinciding with expiry -> normal completion, o_timeout=0.
- i_rst_n low in BUS cycle 2 -> cyc=0 and all outputs 0 without waiting for a clock edge; after release, IDLE, and a fresh i_req runs normally.

Source files
------------

// File: rtl/serv_mem_seq.sv
// rtl/serv_mem_seq.sv - sequencer for the SERV bit-serial load/store/shift buffer
module serv_mem_seq #(
  parameter bit MISALIGN_TRAP = 1'b1,
  parameter int BUS_TIMEOUT   = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_shift_op,
  input  logic       i_store,
  input  logic [1:0] i_size,
  input  logic [1:0] i_lsb,
  input  logic       i_sh_done,
  input  logic       i_dbus_ack,
  output logic       o_init,
  output logic       o_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_byte_valid,
  output logic       o_load,
  output logic       o_dbus_cyc,
  output logic       o_dbus_we,
  output logic [3:0] o_dbus_sel,
  output logic       o_misalign,
  output logic       o_timeout,
  output logic       o_busy,
  output logic       o_done
);

  // A zero timeout still needs a one-bit counter to keep the datapath legal.
  localparam int TW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_BUS,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [4:0]    cnt;
  logic [TW-1:0] wait_cnt;
  logic          shift_q;
  logic          store_q;
  logic [1:0]    size_q;
  logic [1:0]    lsb_q;
  logic          cyc_q;
  logic          misalign_q;
  logic          timeout_q;

  logic [3:0]    sel;
  logic          misaligned;
  logic          wait_expired;
  logic [1:0]    lane;

  // Byte-lane select from the captured size and address offset.
  always_comb begin
    sel = 4'b1111;
    case (size_q)
      2'd0:    sel = 4'b0001 << lsb_q;
      2'd1:    sel = 4'b0011 << lsb_q;
      default: sel = 4'b1111;
    endcase
  end

  assign misaligned   = ((size_q == 2'd1) & lsb_q[0]) | (size_q[1] & (lsb_q != 2'd0));
  // The last permitted wait cycle is BUS_TIMEOUT-1; zero means wait forever.
  assign wait_expired = (BUS_TIMEOUT != 0) && (wait_cnt == TW'(BUS_TIMEOUT - 1));

  // Main sequencer: phase control, counters, bus request and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= 5'd0;
      wait_cnt   <= '0;
      shift_q    <= 1'b0;
      store_q    <= 1'b0;
      size_q     <= 2'd0;
      lsb_q      <= 2'd0;
      cyc_q      <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req) begin
            shift_q <= i_shift_op;
            store_q <= i_store & ~i_shift_op;
            size_q  <= i_size;
            lsb_q   <= i_lsb;
            cnt     <= 5'd0;
            state   <= S_INIT;
          end
        end
        S_INIT: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            if (shift_q) begin
              state <= S_RUN;
            end else if (MISALIGN_TRAP && misaligned) begin
              misalign_q <= 1'b1;
              state      <= S_DONE;
            end else begin
              cyc_q    <= 1'b1;
              wait_cnt <= '0;
              state    <= S_BUS;
            end
          end
        end
        S_BUS: begin
          wait_cnt <= wait_cnt + 1'b1;
          // Ack is checked first so a late ack beats an expiring timer.
          if (i_dbus_ack) begin
            cyc_q <= 1'b0;
            state <= store_q ? S_DONE : S_RUN;
          end else if (wait_expired) begin
            cyc_q     <= 1'b0;
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (shift_q) begin
            if (i_sh_done) begin
              cnt   <= 5'd0;
              state <= S_DONE;
            end
          end else if (cnt == 5'd31) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign lane = cnt[4:3];

  // Decoded outputs; all qualified by state so they read zero in reset.
  always_comb begin
    o_init       = (state == S_INIT);
    o_en         = (state == S_INIT) | ((state == S_RUN) & ~(shift_q & i_sh_done));
    o_cnt        = cnt;
    o_cnt_done   = (cnt == 5'd31) & ((state == S_INIT) | (state == S_RUN));
    o_byte_valid = ((state == S_INIT) & store_q & ~shift_q & (lane >= lsb_q)) |
                   ((state == S_RUN) & ~shift_q &
                    ((lane == 2'd0) | ((lane == 2'd1) & (size_q != 2'd0)) | size_q[1]));
    o_load       = (state == S_BUS) & i_dbus_ack & ~store_q;
    o_dbus_cyc   = cyc_q;
    o_dbus_we    = cyc_q & store_q;
    o_dbus_sel   = cyc_q ? sel : 4'b0000;
    o_misalign   = misalign_q;
    o_timeout    = timeout_q;
    o_busy       = (state != S_IDLE);
    o_done       = (state == S_DONE);
  end

endmodule

// File: tb/tb_serv_mem_seq.sv
// tb/tb_serv_mem_seq.sv - directed self-checking bench for serv_mem_seq
module tb_serv_mem_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       shift_op = 1'b0;
  logic       store = 1'b0;
  logic [1:0] size = 2'd0;
  logic [1:0] lsb = 2'd0;
  logic       sh_done = 1'b0;
  logic       ack = 1'b0;
  logic       use_b = 1'b0;

  logic       a_init, a_en, a_cnt_done, a_bv, a_load, a_cyc, a_we, a_mis, a_to, a_busy, a_done;
  logic [4:0] a_cnt;
  logic [3:0] a_sel;
  logic       b_init, b_en, b_cnt_done, b_bv, b_load, b_cyc, b_we, b_mis, b_to, b_busy, b_done;
  logic [4:0] b_cnt;
  logic [3:0] b_sel;

  always #5 clk = ~clk;

  // A: trapping, short timeout.  B: no trap, default timeout.
  serv_mem_seq #(.MISALIGN_TRAP(1'b1), .BUS_TIMEOUT(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_shift_op(shift_op), .i_store(store),
    .i_size(size), .i_lsb(lsb), .i_sh_done(sh_done), .i_dbus_ack(ack),
    .o_init(a_init), .o_en(a_en), .o_cnt(a_cnt), .o_cnt_done(a_cnt_done),
    .o_byte_valid(a_bv), .o_load(a_load), .o_dbus_cyc(a_cyc), .o_dbus_we(a_we),
    .o_dbus_sel(a_sel), .o_misalign(a_mis), .o_timeout(a_to), .o_busy(a_busy), .o_done(a_done)
  );

  serv_mem_seq #(.MISALIGN_TRAP(1'b0), .BUS_TIMEOUT(255)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_shift_op(shift_op), .i_store(store),
    .i_size(size), .i_lsb(lsb), .i_sh_done(sh_done), .i_dbus_ack(ack),
    .o_init(b_init), .o_en(b_en), .o_cnt(b_cnt), .o_cnt_done(b_cnt_done),
    .o_byte_valid(b_bv), .o_load(b_load), .o_dbus_cyc(b_cyc), .o_dbus_we(b_we),
    .o_dbus_sel(b_sel), .o_misalign(b_mis), .o_timeout(b_to), .o_busy(b_busy), .o_done(b_done)
  );

  logic [19:0] a_all, b_all;
  assign a_all = {a_init, a_en, a_cnt, a_cnt_done, a_bv, a_load, a_cyc, a_we, a_sel, a_mis, a_to, a_busy, a_done};
  assign b_all = {b_init, b_en, b_cnt, b_cnt_done, b_bv, b_load, b_cyc, b_we, b_sel, b_mis, b_to, b_busy, b_done};

  logic       m_init, m_en, m_cnt_done, m_bv, m_load, m_cyc, m_we, m_mis, m_to, m_busy, m_done;
  logic [4:0] m_cnt;
  logic [3:0] m_sel;
  assign m_init     = use_b ? b_init     : a_init;
  assign m_en       = use_b ? b_en       : a_en;
  assign m_cnt      = use_b ? b_cnt      : a_cnt;
  assign m_cnt_done = use_b ? b_cnt_done : a_cnt_done;
  assign m_bv       = use_b ? b_bv       : a_bv;
  assign m_load     = use_b ? b_load     : a_load;
  assign m_cyc      = use_b ? b_cyc      : a_cyc;
  assign m_we       = use_b ? b_we       : a_we;
  assign m_sel      = use_b ? b_sel      : a_sel;
  assign m_mis      = use_b ? b_mis      : a_mis;
  assign m_to       = use_b ? b_to       : a_to;
  assign m_busy     = use_b ? b_busy     : a_busy;
  assign m_done     = use_b ? b_done     : a_done;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int n_busy, n_init, n_run, n_en, n_cyc, n_we, n_load, n_load_bad, n_mis, n_to, n_done;
  int n_cd, n_bv, cnt_err, bv_err, done_idx, mis_idx, to_idx, idle_busy;
  logic [3:0] sel_seen;

  // Issue one operation and collect per-cycle observations until o_done.
  task automatic run_op(input bit on_b, input bit sh, input bit st, input logic [1:0] sz,
                        input logic [1:0] ls, input int ack_wait, input int sh_wait,
                        input bit poke_req);
    bit run, exp_bv;
    logic [1:0] ln;
    n_busy = 0; n_init = 0; n_run = 0; n_en = 0; n_cyc = 0; n_we = 0; n_load = 0;
    n_load_bad = 0; n_mis = 0; n_to = 0; n_done = 0; n_cd = 0; n_bv = 0; cnt_err = 0;
    bv_err = 0; done_idx = -1; mis_idx = -1; to_idx = -1; idle_busy = -1; sel_seen = 4'd0;
    use_b = on_b; shift_op = sh; store = st; size = sz; lsb = ls;
    @(posedge clk); #1;
    if (on_b) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    for (int k = 0; k < 300; k++) begin
      ack     = (ack_wait >= 0) && m_cyc && (n_cyc == ack_wait);
      sh_done = sh && m_busy && !m_init && !m_done && (n_run == sh_wait);
      if (poke_req && (k % 5 == 2)) begin
        if (on_b) req_b = 1'b1; else req_a = 1'b1;
      end
      @(negedge clk);
      run = m_busy && !m_init && !m_cyc && !m_done;
      exp_bv = 1'b0;
      if (m_busy) n_busy++;
      if (m_init) begin
        if (m_cnt != n_init[4:0]) cnt_err++;
        ln = n_init[4:3];
        exp_bv = st && !sh && (ln >= ls);
        n_init++;
      end else if (run) begin
        if (m_cnt != n_run[4:0]) cnt_err++;
        ln = n_run[4:0] >> 3;
        exp_bv = !sh && ((ln == 2'd0) || ((ln == 2'd1) && (sz != 2'd0)) || sz[1]);
        n_run++;
      end
      if (!m_init && m_en) n_en++;
      if (m_bv != exp_bv) bv_err++;
      if (m_bv) n_bv++;
      if (m_cnt_done) n_cd++;
      if (m_cyc) begin
        n_cyc++;
        if (m_we) n_we++;
        sel_seen = m_sel;
      end
      if (m_load) begin
        n_load++;
        if (!(m_cyc && ack)) n_load_bad++;
      end
      if (m_mis) begin n_mis++; mis_idx = k; end
      if (m_to)  begin n_to++;  to_idx = k;  end
      if (m_done) begin
        n_done++;
        done_idx = k;
        @(posedge clk); #1;
        ack = 1'b0; sh_done = 1'b0; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        idle_busy = m_busy;
        break;
      end
      @(posedge clk); #1;
      req_a = 1'b0; req_b = 1'b0;
    end
    ack = 1'b0; sh_done = 1'b0; req_a = 1'b0; req_b = 1'b0;
    chk("op_completed", n_done, 1);
  endtask

  int bus_seen;

  initial begin
    // Reset state, with live inputs that must not leak through.
    ack = 1'b1; req_a = 1'b1; req_b = 1'b1;
    #2;
    chk("reset_a_outputs", int'(a_all), 0);
    chk("reset_b_outputs", int'(b_all), 0);
    ack = 1'b0; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", int'(a_all), 0);

    // Store byte, lsb=2, ack after three wait cycles.
    run_op(1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 3, 0, 1'b0);
    chk("st_init_cycles", n_init, 32);
    chk("st_cnt_err", cnt_err, 0);
    chk("st_bv_err", bv_err, 0);
    chk("st_bv_count", n_bv, 16);
    chk("st_cyc_cycles", n_cyc, 4);
    chk("st_we_cycles", n_we, 4);
    chk("st_sel", int'(sel_seen), 4);
    chk("st_load", n_load, 0);
    chk("st_cnt_done", n_cd, 1);
    chk("st_done_idx", done_idx, 36);
    chk("st_busy", n_busy, 37);
    chk("st_idle_after", idle_busy, 0);

    // Load word, ack on the first bus cycle.
    run_op(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 0, 0, 1'b0);
    chk("lw_cyc_cycles", n_cyc, 1);
    chk("lw_sel", int'(sel_seen), 15);
    chk("lw_we", n_we, 0);
    chk("lw_load", n_load, 1);
    chk("lw_load_bad", n_load_bad, 0);
    chk("lw_run_en", n_en, 32);
    chk("lw_bv_count", n_bv, 32);
    chk("lw_bv_err", bv_err, 0);
    chk("lw_cnt_err", cnt_err, 0);
    chk("lw_cnt_done", n_cd, 2);
    chk("lw_done_idx", done_idx, 65);
    chk("lw_busy", n_busy, 66);

    // Misaligned half load, trapping instance.
    run_op(1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 0, 0, 1'b0);
    chk("mis_cyc", n_cyc, 0);
    chk("mis_pulses", n_mis, 1);
    chk("mis_idx", mis_idx, 32);
    chk("mis_done_idx", done_idx, 32);
    chk("mis_load", n_load, 0);

    // Same access on the non-trapping instance.
    run_op(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 0, 0, 1'b0);
    chk("nt_cyc", n_cyc, 1);
    chk("nt_sel", int'(sel_seen), 6);
    chk("nt_mis", n_mis, 0);
    chk("nt_load", n_load, 1);
    chk("nt_bv_count", n_bv, 16);
    chk("nt_bv_err", bv_err, 0);
    chk("nt_busy", n_busy, 66);

    // Shift op, sh_done six cycles into RUN, with stray requests.
    run_op(1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 0, 6, 1'b1);
    chk("sh_cyc", n_cyc, 0);
    chk("sh_run_en", n_en, 6);
    chk("sh_bv", n_bv, 0);
    chk("sh_cnt_err", cnt_err, 0);
    chk("sh_done_idx", done_idx, 39);
    chk("sh_busy", n_busy, 40);
    chk("sh_idle_after", idle_busy, 0);

    // Load with no ack: bus timeout.
    run_op(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, -1, 0, 1'b0);
    chk("to_cyc", n_cyc, 4);
    chk("to_pulses", n_to, 1);
    chk("to_idx", to_idx, 36);
    chk("to_done_idx", done_idx, 36);
    chk("to_load", n_load, 0);
    chk("to_run_en", n_en, 0);

    // Ack in the same cycle the timer expires.
    run_op(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3, 0, 1'b0);
    chk("ackexp_cyc", n_cyc, 4);
    chk("ackexp_timeout", n_to, 0);
    chk("ackexp_load", n_load, 1);
    chk("ackexp_busy", n_busy, 69);

    // Reset asserted in bus cycle 2 of a load.
    use_b = 1'b0; shift_op = 1'b0; store = 1'b0; size = 2'd2; lsb = 2'd0;
    @(posedge clk); #1;
    req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    bus_seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (a_cyc) bus_seen++;
      if (bus_seen == 2) break;
      @(posedge clk); #1;
    end
    chk("rst_reached_bus2", bus_seen, 2);
    ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", int'(a_cyc), 0);
    chk("rst_async_all", int'(a_all), 0);
    ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", int'(a_all), 0);
    run_op(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 0, 0, 1'b0);
    chk("rst_fresh_load", n_load, 1);
    chk("rst_fresh_busy", n_busy, 66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
